// File: rtl/status_text_pkg.sv
// Shared types and constants for the status number text overlay source.
package status_text_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_FMT,
        ST_WAIT,
        ST_COMMIT
    } state_t;

    localparam logic [6:0]  ASCII_SPACE = 7'h20;
    localparam logic [6:0]  ASCII_ZERO  = 7'h30;
    localparam int unsigned BCD_DIGITS  = 5;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter, one bit per clock.
module bin2bcd_seq
    import status_text_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      din,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [15:0]      sr_q, sr_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             run_q, run_d;

    // Load on start, then adjust-and-shift one input bit (MSB first) per cycle.
    always_comb begin
        sr_d  = sr_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            sr_d  = din;
            bcd_d = '0;
            cnt_d = 4'd15;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = (dd_adjust(bcd_q) << 1) | {{(BCD_W-1){1'b0}}, sr_q[15]};
            sr_d  = {sr_q[14:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
                run_d = 1'b0;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // done marks the cycle whose edge performs the final shift.
    assign done = run_q && (cnt_q == 4'd0);
    assign bcd  = bcd_q;

endmodule

// File: rtl/status_num_text_ctrl.sv
// Binary status value to right-aligned decimal ASCII field for the character
// overlay; the visible text only changes on a vertical-blank rising edge.
module status_num_text_ctrl
    import status_text_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned LEAD_BLANK = 1,
    parameter int unsigned COL_OFFSET = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        vblnk_in,
    input  logic [7:0]  char_xy,
    output logic [6:0]  char_code,
    output logic        busy
);

    state_t                      state_q, state_d;
    logic                        ready_q, ready_d;
    logic                        busy_q, busy_d;
    logic                        vblnk_q, vblnk_d;
    logic [NUM_DIGITS-1:0][6:0]  shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][6:0]  display_q, display_d;
    logic [6:0]                  char_code_q, char_code_d;

    logic                        accept;
    logic                        bcd_done;
    logic [BCD_W-1:0]            bcd;
    logic [NUM_DIGITS-1:0][6:0]  fmt_text;
    logic                        lead;
    logic [4:0]                  col_rel;

    assign accept = (state_q == ST_IDLE) && ready_q && value_valid;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .din   (value_in),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // BCD to ASCII, blanking leading zeros from the most-significant shown digit
    // down; index 0 is the least-significant digit and is never blanked.
    always_comb begin
        fmt_text = '0;
        lead     = (LEAD_BLANK != 0);
        for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
            if (lead && (bcd[(i-1)*4 +: 4] == 4'd0) && (i > 1)) begin
                fmt_text[i-1] = ASCII_SPACE;
            end else begin
                fmt_text[i-1] = ASCII_ZERO + {3'b000, bcd[(i-1)*4 +: 4]};
                lead          = 1'b0;
            end
        end
    end

    // Controller next-state: handshake, conversion sequencing, vblank-gated commit.
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        shadow_d  = shadow_q;
        display_d = display_q;
        vblnk_d   = vblnk_in;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    state_d = ST_CONV;
                    ready_d = 1'b0;
                end
            end
            ST_CONV: begin
                if (bcd_done) begin
                    state_d = ST_FMT;
                end
            end
            ST_FMT: begin
                shadow_d = fmt_text;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (vblnk_in && !vblnk_q) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                display_d = shadow_q;
                state_d   = ST_IDLE;
                ready_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Read path: column relative to the field start; negative offsets wrap to
    // values >= 16 and so never match a digit slot.
    always_comb begin
        col_rel     = {1'b0, char_xy[3:0]} - 5'(COL_OFFSET);
        char_code_d = ASCII_SPACE;
        if (char_xy[7:4] == 4'd0) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (col_rel == 5'(NUM_DIGITS - 1 - k)) begin
                    char_code_d = display_q[k];
                end
            end
        end
    end

    // Controller registers, including the registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            vblnk_q     <= 1'b0;
            shadow_q    <= {NUM_DIGITS{ASCII_SPACE}};
            display_q   <= {NUM_DIGITS{ASCII_SPACE}};
            char_code_q <= ASCII_SPACE;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            vblnk_q     <= vblnk_d;
            shadow_q    <= shadow_d;
            display_q   <= display_d;
            char_code_q <= char_code_d;
        end
    end

    assign value_ready = ready_q;
    assign busy        = busy_q;
    assign char_code   = char_code_q;

endmodule

// File: tb/tb_status_num_text_ctrl.sv
// Self-checking bench for status_num_text_ctrl: three parameterisations run in
// lockstep against a decimal-arithmetic reference of the displayed field.
module tb_status_num_text_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        value_valid;
    logic        vblnk_in;
    logic [7:0]  char_xy;

    logic       ready_a, busy_a, ready_b, busy_b, ready_c, busy_c;
    logic [6:0] code_a, code_b, code_c;

    int checks = 0;
    int errors = 0;
    int model_val = -1;   // value currently committed to the display, -1 = blank

    always #5 clk = ~clk;

    status_num_text_ctrl dut_a (
        .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
        .value_ready(ready_a), .vblnk_in(vblnk_in), .char_xy(char_xy),
        .char_code(code_a), .busy(busy_a)
    );

    status_num_text_ctrl #(.LEAD_BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
        .value_ready(ready_b), .vblnk_in(vblnk_in), .char_xy(char_xy),
        .char_code(code_b), .busy(busy_b)
    );

    status_num_text_ctrl #(.NUM_DIGITS(3), .COL_OFFSET(4)) dut_c (
        .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
        .value_ready(ready_c), .vblnk_in(vblnk_in), .char_xy(char_xy),
        .char_code(code_c), .busy(busy_c)
    );

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Expected character at xy for a field of nd digits showing val.
    function automatic logic [6:0] exp_char(input int val, input int nd, input int lb,
                                            input int off, input logic [7:0] xy);
        int row, col, pos, v;
        row = int'(xy[7:4]);
        col = int'(xy[3:0]);
        if (val < 0 || row != 0 || col < off || col >= off + nd) return 7'h20;
        pos = nd - 1 - (col - off);
        v   = val % pow10(nd);
        if (lb != 0 && pos > 0 && v < pow10(pos)) return 7'h20;
        return 7'(48 + (v / pow10(pos)) % 10);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_codes(input string tag, input logic [7:0] xy);
        chk($sformatf("%s_a_%h", tag, xy), 16'(code_a), 16'(exp_char(model_val, 5, 1, 0, xy)));
        chk($sformatf("%s_b_%h", tag, xy), 16'(code_b), 16'(exp_char(model_val, 5, 0, 0, xy)));
        chk($sformatf("%s_c_%h", tag, xy), 16'(code_c), 16'(exp_char(model_val, 3, 1, 4, xy)));
    endtask

    task automatic read_one(input logic [7:0] xy);
        char_xy = xy;
        tick();
        chk_codes("rd", xy);
    endtask

    task automatic read_all;
        for (int c = 0; c < 16; c++) read_one(8'(c));
        read_one(8'h10);
        read_one({4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))});
    endtask

    // Offer v until accepted (bounded); optionally keep valid high afterwards.
    task automatic send(input int v, input bit hold);
        bit got = 1'b0;
        bit rdy;
        value_in    = 16'(v);
        value_valid = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            rdy = ready_a;
            tick();
            if (rdy) got = 1'b1;
        end
        chk("accept", 16'(got), 16'd1);
        if (!hold) value_valid = 1'b0;
        chk("busy_after_accept", 16'({busy_a, busy_b, busy_c}), 16'b111);
        chk("ready_after_accept", 16'({ready_a, ready_b, ready_c}), 16'b000);
    endtask

    // Run through CONV and FMT into WAIT; optional stray vblank/valid pulse.
    task automatic conv_wait(input int glitch_at);
        for (int i = 1; i <= 18; i++) begin
            if (glitch_at > 0 && i == glitch_at) begin
                vblnk_in    = 1'b1;
                value_valid = 1'b1;
                value_in    = 16'($urandom);
            end
            if (glitch_at > 0 && i == glitch_at + 2) begin
                vblnk_in    = 1'b0;
                value_valid = 1'b0;
            end
            tick();
            chk("ready_low_busy", 16'({ready_a, busy_a}), 16'b01);
        end
    endtask

    task automatic vblank_commit(input int new_val);
        vblnk_in = 1'b1;
        tick();
        chk("busy_commit", 16'(busy_a), 16'd1);
        tick();
        chk("idle_after_commit", 16'({ready_a, busy_a}), 16'b10);
        vblnk_in  = 1'b0;
        model_val = new_val;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        rst = 1'b1; value_in = '0; value_valid = 1'b0; vblnk_in = 1'b0; char_xy = '0;
        #1;
        chk("rst_code", 16'({code_a, code_b, code_c}), 16'({7'h20, 7'h20}) | 16'h0);
        tick(); tick();
        chk("rst_code_a", 16'(code_a), 16'h20);
        chk("rst_busy", 16'({busy_a, busy_b, busy_c}), 16'b000);
        chk("rst_ready", 16'({ready_a, ready_b, ready_c}), 16'b000);
        rst = 1'b0;
        chk("ready_before_clk", 16'(ready_a), 16'd0);
        tick();
        chk("ready_after_release", 16'({ready_a, ready_b, ready_c}), 16'b111);
        read_all();

        // Directed values
        send(12345, 1'b0); conv_wait(0); vblank_commit(12345); read_all();
        send(42, 1'b0);    conv_wait(0); vblank_commit(42);    read_all();
        send(0, 1'b0);     conv_wait(0); vblank_commit(0);     read_all();
        send(1234, 1'b0);  conv_wait(0); vblank_commit(1234);  read_all();

        // Back-to-back requests with valid held high
        send(7, 1'b1);
        value_in = 16'd9;
        conv_wait(0);
        vblank_commit(7);
        send(9, 1'b0);
        read_all();
        vblank_commit(9);
        read_all();

        // Tearing: accept while vblank already high; commit only on the next rise
        send(111, 1'b0); conv_wait(0); vblank_commit(111); read_all();
        vblnk_in = 1'b1;
        tick(); tick();
        send(65535, 1'b0);
        conv_wait(0);
        read_all();
        vblnk_in = 1'b0;
        read_all();
        char_xy  = 8'h04;
        vblnk_in = 1'b1;
        tick();
        chk_codes("tear_e0", 8'h04);
        tick();
        chk_codes("tear_e1", 8'h04);
        model_val = 65535;
        vblnk_in  = 1'b0;
        tick();
        chk_codes("tear_e2", 8'h04);
        read_all();

        // Randomised values with stray vblank/valid pulses during conversion
        for (int it = 0; it < 8; it++) begin
            v = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) v = v % 1000;
            send(v, 1'b0);
            conv_wait(int'($urandom_range(2, 12)));
            read_all();
            vblank_commit(v);
            read_all();
            tick();
            chk("stay_idle", 16'({ready_a, busy_a}), 16'b10);
        end

        // Reset in the middle of a conversion
        send(12, 1'b0);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 16'({busy_a, busy_b, busy_c}), 16'b000);
        chk("midrst_ready", 16'(ready_a), 16'd0);
        chk("midrst_code", 16'(code_a), 16'h20);
        model_val = -1;
        tick();
        chk("midrst_ready_held", 16'(ready_a), 16'd0);
        rst = 1'b0;
        tick();
        chk("midrst_ready_release", 16'({ready_a, busy_a}), 16'b10);
        read_all();
        send(5, 1'b0); conv_wait(0); vblank_commit(5); read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_num_text_ctrl.md
Name: status_num_text_ctrl

Overview:
- Converts a 16-bit binary status value into right-aligned decimal ASCII text.
- Serves that text as character codes to the character-cell overlay pipeline, addressed by the overlay's char_xy output.
- Conversion is sequential (double-dabble, one bit per clock) into a shadow buffer.
- The visible buffer is committed only at a vertical-blank rising edge, so a frame never shows a half-updated number.
- Sits between the status/logic source and the font ROM lookup stage of the overlay chain.

Parameters:
- NUM_DIGITS, 5, number of displayed decimal digits (1..5); more-significant digits are truncated.
- LEAD_BLANK, 1, 1 = leading zeros shown as space (0x20); least-significant digit is always shown.
- COL_OFFSET, 0, first character column of the field in row 0 (0..15-NUM_DIGITS).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- value_in  in  16  binary value to display.
- value_valid  in  1  source offers value_in.
- value_ready  out  1  block can accept a value (IDLE only).
- vblnk_in  in  1  vertical blank from the timing chain.
- char_xy  in  8  {row[3:0], col[3:0]} character-cell address from the overlay.
- char_code  out  7  ASCII code for char_xy, to the font ROM address.
- busy  out  1  conversion or commit pending.

Behaviour:
- Reset values:
  - FSM=IDLE; value_ready=0 during reset and 1 from the first clock after release.
  - busy=0.
  - char_code=0x20.
  - Shadow and display digit registers = blank (0x20).
  - vblnk_q=0.
- Handshake: value is accepted when value_valid && value_ready at a clk edge. value_in is captured that cycle and the FSM enters CONV. value_ready=0 in every state except IDLE. The source holds valid until accepted; there is no queueing.
- FSM:
  - IDLE: on accept -> CONV, bit counter=15.
  - CONV: 16 cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts left by one bit, inserting the next MSB of the captured value. On counter==0 -> FMT.
  - FMT: 1 cycle. Converts the BCD nibbles to ASCII (0x30+d). Applies leading blanking when LEAD_BLANK=1: the scan runs from the most-significant displayed digit and stops at the first nonzero digit or at the least-significant digit. Result is written to the shadow buffer -> WAIT.
  - WAIT: waits for vblnk rise = vblnk_in && !vblnk_q. A rise that occurred before WAIT is ignored. On rise -> COMMIT.
  - COMMIT: 1 cycle. The shadow buffer is copied in parallel to the display buffer -> IDLE.
- busy=1 in CONV, FMT, WAIT, COMMIT.
- Accept-to-commit latency: 18 cycles plus the wait for vblank.
- Read path: char_code is registered, 1-cycle latency from char_xy. Matches the overlay's registered char_xy/char_line timing.
  - row==0 and COL_OFFSET <= col < COL_OFFSET+NUM_DIGITS: returns display digit, index col-COL_OFFSET, most-significant digit first.
  - Any other address: 0x20.
- Display buffer changes only in COMMIT. Reads in that same cycle return the old value; the new value appears from the next cycle.
- Values >= 10^NUM_DIGITS: only the low NUM_DIGITS decimal digits are shown, with no overflow flag.
- Reset mid-operation: conversion is aborted, both buffers are blanked, and the FSM returns to IDLE.
- vblnk_in held high across WAIT entry does not trigger COMMIT; a fresh rising edge is required.
- value_valid that drops before acceptance: ignored, no state change.

Decomposition:
- Shared package status_text_pkg:
  - FSM state enum (IDLE, CONV, FMT, WAIT, COMMIT).
  - ASCII_SPACE=7'h20, ASCII_ZERO=7'h30.
  - BCD width constant (20 bits = 5 nibbles).
- One sub-module: bin2bcd_seq. Sequential double-dabble with start/done, 16-bit in, 20-bit BCD out. The controller FSM owns it.

Test Plan:
- Defaults; value 12345 accepted, then one vblank rise -> char_xy 0x00..0x04 read back 0x31,0x32,0x33,0x34,0x35 one cycle later; char_xy 0x05 and 0x10 -> 0x20.
- Value 42, LEAD_BLANK=1 -> cols 0..4 = 0x20,0x20,0x20,0x34,0x32. Value 0 -> 0x20 x4, 0x30. With LEAD_BLANK=0, value 42 -> 0x30,0x30,0x30,0x34,0x32.
- Tearing check: display shows 111. Accept 65535 while vblnk_in=1 (already high). Display stays 0x31 across the remainder of that blank and the next active frame, and updates only one cycle after the next vblnk rise, to 0x36,0x35,0x35,0x33,0x35.
- Handshake: valid held with 7 then 9 on back-to-back requests -> value_ready=0 for CONV..COMMIT. The second value is accepted only after return to IDLE, and both commit in order on successive vblank rises.
- NUM_DIGITS=3, COL_OFFSET=4, value 1234 -> cols 4..6 = 0x32,0x33,0x34; col 3 and col 7 = 0x20.
- Assert rst during CONV (cycle 8) -> busy=0, value_ready=0 then 1, all reads 0x20. A new value of 5 then commits normally to "    5".
